// File: rtl/alu_seq_if.sv
// Handshake bus for alu_seq: operand/op request side and result/flag response side.
// The DUT takes the slave modport; the producer/consumer takes the master modport.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle add/sub/logic ops and a
// WIDTH-step shift-add unsigned multiply, with carry/overflow/zero flags.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] acc_step;

    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign sum_w    = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w   = {1'b0, bus.a} - {1'b0, bus.b};
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        case (bus.op)
                            OP_ADD: begin
                                result_d = sum_w[WIDTH-1:0];
                                carry_d  = sum_w[WIDTH];
                                ovf_d    = add_ovf($signed(bus.a), $signed(bus.b),
                                                   $signed(sum_w[WIDTH-1:0]));
                            end
                            OP_SUB: begin
                                result_d = diff_w[WIDTH-1:0];
                                carry_d  = diff_w[WIDTH];
                                ovf_d    = sub_ovf($signed(bus.a), $signed(bus.b),
                                                   $signed(diff_w[WIDTH-1:0]));
                            end
                            OP_AND:  result_d = bus.a & bus.b;
                            OP_OR:   result_d = bus.a | bus.b;
                            OP_XOR:  result_d = bus.a ^ bus.b;
                            OP_NOR:  result_d = ~(bus.a | bus.b);
                            default: result_d = '0;  // reserved opcode yields a defined zero
                        endcase
                        zero_d  = (result_d == '0);
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_step[WIDTH-1:0];
                    carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                    ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, randomized ops against an arithmetic
// reference model, and hand-written backpressure / mid-multiply reset sequences.
module tb_alu_seq;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        vec_t r;
        int ua, ub, sa, sb, full, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        r.op = op; r.a = a; r.b = b;
        r.c = 1'b0; r.v = 1'b0; r.res = '0;
        case (op)
            3'd0: begin
                full = ua + ub; r.res = W'(full % M); r.c = (full >= M);
                s = sa + sb;    r.v = (s > M/2 - 1) || (s < -M/2);
            end
            3'd1: begin
                full = ua - ub; r.res = W'((full + M) % M); r.c = (ua < ub);
                s = sa - sb;    r.v = (s > M/2 - 1) || (s < -M/2);
            end
            3'd2: begin
                full = ua * ub; r.res = W'(full % M);
                r.c = (full >= M); r.v = (full >= M);
            end
            3'd3: r.res = '0;
            3'd4: r.res = a & b;
            3'd5: r.res = a | b;
            3'd6: r.res = a ^ b;
            default: r.res = ~(a | b);
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    // Called at a negedge with the block idle; returns after the output handshake.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rdy_early, output vec_t got, output int edges,
                          output logic rdy_seen);
        bus.op = op; bus.a = a; bus.b = b;
        bus.in_valid = 1'b1;
        bus.out_ready = rdy_early;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = ~a;
        bus.b = W'($urandom);
        bus.op = 3'($urandom);
        edges = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && edges < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            edges++;
        end
        got.op = op; got.a = a; got.b = b;
        got.res = bus.result; got.c = bus.carry; got.v = bus.overflow; got.z = bus.zero;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic apply_check(input string name, input vec_t exp, input logic rdy_early);
        vec_t got;
        int edges;
        logic rdy_seen;
        run_op(exp.op, exp.a, exp.b, rdy_early, got, edges, rdy_seen);
        check({name, ".result"}, 32'(got.res), 32'(exp.res));
        check({name, ".carry"}, 32'(got.c), 32'(exp.c));
        check({name, ".overflow"}, 32'(got.v), 32'(exp.v));
        check({name, ".zero"}, 32'(got.z), 32'(exp.z));
        check({name, ".latency"}, 32'(edges), (exp.op == 3'd2) ? 32'(W) : 32'd0);
        check({name, ".in_ready_busy"}, 32'(rdy_seen), 32'd0);
        check({name, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({name, ".out_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{3'd0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 8'd100, 8'd50,  8'h96, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{3'd1, 8'd5,   8'd7,   8'hFE, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{3'd1, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{3'd2, 8'd15,  8'd17,  8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd2, 8'd16,  8'd16,  8'h00, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{3'd7, 8'hF0,  8'h0F,  8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'd6, 8'hAA,  8'hFF,  8'h55, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd3, 8'h12,  8'h34,  8'h00, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'd4, 8'hCC,  8'hAA,  8'h88, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd5, 8'hC0,  8'h03,  8'hC3, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{3'd2, 8'hFF,  8'hFF,  8'h01, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.op = '0;
        repeat (3) @(negedge clk);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.flags", {29'd0, bus.carry, bus.overflow, bus.zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            apply_check($sformatf("tbl%0d", i), tbl[i], 1'(i % 2));

        for (int i = 0; i < 40; i++) begin
            logic [2:0] rop;
            logic [W-1:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = W'(M - 1);
            apply_check($sformatf("rnd%0d_op%0d", i, rop), model(rop, ra, rb), 1'($urandom_range(0, 1)));
        end

        // Backpressure: DONE held, new requests ignored and not queued.
        bus.op = 3'd0; bus.a = 8'd200; bus.b = 8'd100;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp.out_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 8'h0F; bus.b = 8'h0F;
            @(negedge clk);
            check($sformatf("bp%0d.out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d.result", k), 32'(bus.result), 32'h2C);
            check($sformatf("bp%0d.flags", k), {29'd0, bus.carry, bus.overflow, bus.zero}, 32'b100);
            check($sformatf("bp%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.in_ready_after", 32'(bus.in_ready), 32'd1);
        check("bp.out_valid_after", 32'(bus.out_valid), 32'd0);
        begin
            logic seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            check("bp.no_queued_op", 32'(seen), 32'd0);
        end

        // Reset asserted on the third cycle of a multiply aborts it silently.
        bus.op = 3'd2; bus.a = 8'd15; bus.b = 8'd17;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmul.busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmul.in_ready", 32'(bus.in_ready), 32'd1);
        check("rstmul.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmul.result", 32'(bus.result), 32'd0);
        check("rstmul.flags", {29'd0, bus.carry, bus.overflow, bus.zero}, 32'd0);
        rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            check("rstmul.no_out_valid", 32'(seen), 32'd0);
        end

        apply_check("post_reset_add", model(3'd0, 8'd1, 8'd2), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the lab datapath. Supports the existing add/sub/logic op encoding and adds a multi-cycle unsigned multiply, a defined result for the reserved opcode, and carry/overflow/zero flags. A valid/ready handshake runs on both the input and the output side. The block takes over from the 4-bit combinational ALU wherever a clocked, width-scalable unit is needed.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  WIDTH  operand A (unsigned for carry/borrow, two's complement for overflow)
- b  input  WIDTH  operand B
- op  input  3  000 ADD, 001 SUB, 010 MUL, 011 reserved, 100 AND, 101 OR, 110 XOR, 111 NOR
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- carry  output  1  ADD carry-out; SUB borrow (a<b unsigned); MUL high half ≠0; else 0
- overflow  output  1  ADD/SUB signed overflow; MUL high half ≠0; else 0
- zero  output  1  result == 0

## Operation
- FSM states: IDLE, MUL, DONE. Reset state IDLE.
- Accept: in_valid && in_ready at a rising edge. The edge registers a, b and op. Operand changes after acceptance have no effect.
- In IDLE, an accepted non-MUL op computes the result and flags at the same edge. State goes to DONE.
- In IDLE, an accepted MUL loads the multiplicand, the multiplier and a 2·WIDTH accumulator = 0. Bit counter = 0. State goes to MUL.
- MUL: each edge does one shift-add step, adding the multiplicand when the current multiplier LSB = 1. Counter increments.
  - On the WIDTH-th step: result = low WIDTH bits, carry = overflow = |high WIDTH bits, state goes to DONE.
- DONE: out_valid = 1. result and flags are held stable until out_valid && out_ready at an edge, then state goes to IDLE.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: carry = borrow.
  - ADD/SUB overflow: the operand sign bits agree as required by the op, and the result sign differs.
- Logic ops (100–111): bitwise operation, carry = overflow = 0.
- Reserved 011: result = 0, carry = overflow = 0, zero = 1, latency 1. No latch or undefined hold.
- zero is registered together with result.

## Timing
- Reset: in_ready = 1, out_valid = 0, result = 0, carry = overflow = zero = 0, state IDLE, MUL counter = 0.
- Reset is sampled only at a clock edge. It overrides everything. Asserted mid-MUL or in DONE, it aborts the operation with no out_valid pulse.
- Latency, counted from the accept edge t0 to the edge after which out_valid = 1:
  - non-MUL: out_valid high from t0 (1 cycle)
  - MUL: out_valid high from edge t0+WIDTH (WIDTH cycles after entering MUL)
- in_ready is 0 in MUL and DONE. in_valid is ignored while in_ready = 0, and no operation is queued.
- After the output handshake edge, the block is in IDLE and in_ready = 1 on the next cycle. Maximum throughput for single-cycle ops is one op per 2 cycles.
- out_ready held high before out_valid rises: the handshake completes on the first edge with out_valid = 1.
- out_ready low: DONE is held indefinitely and outputs do not change.

## Test plan
- ADD, WIDTH = 8: a=200, b=100 → result 0x2C, carry 1, overflow 0, zero 0, out_valid one cycle after accept. Then a=100, b=50 → 0x96, carry 0, overflow 1.
- SUB: a=5, b=7 → 0xFE, carry 1, overflow 0. Then a=0x80, b=1 → 0x7F, carry 0, overflow 1.
- MUL: a=15, b=17 → 0xFF, carry 0, overflow 0, out_valid exactly 8 cycles after accept, in_ready 0 throughout. Then a=16, b=16 → 0x00, zero 1, carry 1, overflow 1.
- Logic and reserved ops: NOR 0xF0, 0x0F → 0x00, zero 1. XOR 0xAA, 0xFF → 0x55. op=011 → 0x00, zero 1, carry 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → outputs stable, a new in_valid is ignored. Raise out_ready → IDLE, in_ready = 1 next cycle.
- Reset mid-MUL: assert rst_n = 0 on cycle 3 of a MUL → next edge gives all outputs at their reset values, in_ready = 1, and no out_valid ever appears for the aborted op.
